// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;

  // Bit counter only ever holds (largest loaded length - 1).
  function automatic int cnt_width(input int sync_w, input int data_w, input int gap);
    int m;
    m = 2;
    if (sync_w > m) m = sync_w;
    if (data_w > m) m = data_w;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload handshake and serial output bundle of the framed transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  // Handshake: a word transfers on a rising edge where din_valid and din_ready
  // are both high; din is only looked at on that edge, and din_valid held
  // while din_ready is low has no effect.
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              A;
  logic              bit_valid;
  logic              busy;
  logic              frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, A, bit_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, A, bit_valid, busy, frame_done
  );
endinterface

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; exposes the MSB it will hold next.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              next_msb_o
);

  logic [DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DATA_W-2:0], 1'b0};
    end
  end

  // Lets the parent register A from the post-edge contents.
  assign next_msb_o = sr_d[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/seq_frame_tx.sv
// Framed serial transmitter: sync pattern, MSB-first payload, then idle gap.
module seq_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEFAULT),
  parameter int                GAP      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_frame_tx_if.slave tx,
  output tx_state_e     state_o
);

  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_q, a_d;
  logic              bv_q, bv_d;
  logic              fd_q, fd_d;
  logic [SYNC_W-1:0] sync_sh;
  logic              accept;
  logic              next_msb;

  assign accept = (state_q == ST_IDLE) && tx.din_valid;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .shift_i    (state_q == ST_DATA),
    .din_i      (tx.din),
    .next_msb_o (next_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          cnt_d   = CNT_W'(SYNC_W - 1);
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line outputs are registered, so they are decoded from the next state.
    a_d     = 1'b0;
    bv_d    = 1'b0;
    fd_d    = 1'b0;
    sync_sh = SYNC_PAT >> cnt_d;
    case (state_d)
      ST_SYNC: begin
        a_d  = sync_sh[0];
        bv_d = 1'b1;
      end
      ST_DATA: begin
        a_d  = next_msb;
        bv_d = 1'b1;
        fd_d = (cnt_d == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      bv_q    <= bv_d;
      fd_q    <= fd_d;
    end
  end

  assign tx.A          = a_q;
  assign tx.bit_valid  = bv_q;
  assign tx.frame_done = fd_q;
  assign tx.busy       = (state_q != ST_IDLE);
  assign tx.din_ready  = (state_q == ST_IDLE);
  assign state_o       = state_q;

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial pattern transmitter. Accepts a parallel payload word over a valid/ready handshake and emits it one bit per clock on a serial line.
- Each payload is preceded by a fixed sync pattern and followed by a configurable idle gap.
- Drives the single-bit input of the team's serial sequence detectors. It generates deterministic, framed stimulus where benches currently use random bits, and it is the transmit end of the same serial interface.

Parameters:
- DATA_W, 8, payload width in bits (2..32).
- SYNC_W, 4, sync pattern width in bits (1..16).
- SYNC_PAT, 4'b1101, sync pattern, sent MSB first.
- GAP, 2, idle cycles after each frame (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W  payload word, sampled on handshake.
- din_valid  input  1  payload available.
- din_ready  output  1  transmitter can accept a payload.
- A  output  1  serial bit stream, registered.
- bit_valid  output  1  A carries a sync or payload bit this cycle.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse coincident with the last payload bit.

Behaviour:
- Reset values:
  - Outputs: A=0, bit_valid=0, busy=0, frame_done=0, din_ready=1.
  - Internals: state=IDLE, counters=0, shift register=0.
- Reset is asynchronous. Asserting rst_n low at any point, including mid-frame, forces the reset values immediately and discards the captured word. The first accept after rst_n rises is allowed on the first rising edge.
- FSM states: IDLE, SYNC, DATA, GAP.
- IDLE:
  - din_ready=1, A=0, bit_valid=0.
  - On a rising edge with din_valid=1: capture din into the shift register, load the bit counter with SYNC_W-1, go to SYNC.
- SYNC:
  - A = SYNC_PAT[cnt], MSB first, with bit_valid=1.
  - When cnt=0: load cnt with DATA_W-1 and go to DATA.
- DATA:
  - A = payload MSB, with bit_valid=1. Shift left by one each cycle.
  - When cnt=0: assert frame_done for this cycle. Then go to GAP, loading cnt with GAP-1, or go to IDLE if GAP=0.
- GAP:
  - A=0, bit_valid=0, busy=1, din_ready=0.
  - When cnt=0: go to IDLE.
- Output timing: A, bit_valid, and frame_done are registered and updated with the state. The first sync bit appears in the cycle after the accepting edge.
- Latency: 1 cycle from handshake to first bit. Frame occupies SYNC_W+DATA_W bit cycles plus GAP idle cycles.
- Back-to-back throughput: one frame per 1+SYNC_W+DATA_W+GAP cycles (15 at defaults). There is exactly one IDLE cycle between frames when din_valid is held high.
- din_ready is high only in IDLE. Holding din_valid high while din_ready=0 has no effect, and din is ignored then.
- No bit stuffing: a payload containing SYNC_PAT may trigger a downstream detector. This is accepted behaviour.
- Counters are sized to $clog2 of max(SYNC_W, DATA_W, GAP, 2) and have no wrap-around beyond the loaded value.

Decomposition:
- Package seq_tx_pkg holds:
  - state encoding localparams: IDLE=2'd0, SYNC=2'd1, DATA=2'd2, GAP=2'd3;
  - default SYNC_PAT;
  - a counter-width function.
- One sub-module: piso_shift, a DATA_W parallel-load, MSB-first shift register with load/shift enables.
- The FSM and counters live in seq_frame_tx.

Test Plan:
- Defaults, din=8'hA5 pulsed valid once after reset:
  - A over 12 bit_valid cycles = 1101_10100101;
  - frame_done high on the 12th cycle only;
  - then 2 cycles A=0, busy=1;
  - din_ready returns 1 on the 15th cycle after the accept edge.
- din_valid held high with din=8'h3C then 8'hFF (switched on the accept edge):
  - accepts exactly 15 cycles apart;
  - second frame bits 1101_11111111;
  - no extra captures.
- rst_n pulled low on the 5th payload bit of din=8'h96:
  - A, bit_valid, busy drop to 0 the same instant, din_ready=1;
  - after release, a new accept of 8'h01 yields 1101_00000001.
- GAP=0, DATA_W=4, two back-to-back words 4'h9, 4'h6:
  - stream 1101_1001, one idle cycle, then 1101_0110;
  - frame_done pulses twice.
- din_valid toggled randomly for 256 cycles, with A fed to the team's serial sequence detector:
  - bench scoreboard matches every accepted word against the bits it recovers;
  - bit_valid count = 12 × accepts.
